// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The fetch stage is the master; the memory (or its model) is the slave.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// buffers returned words in a 2-entry {pc, instr} FIFO and flushes on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_F,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_stage_if.master      imem,
    output logic [31:0]        instr_F,
    output logic [31:0]        pc_F,
    output logic               valid_F
);

    // ST_DROP means a request is in flight whose data must be thrown away.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } fetch_state_t;

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  req_pc_reg;
    logic [1:0]   occ_reg, occ_next;
    logic         head_reg;
    logic         tail;
    logic         push, pop, req, handshake;

    logic [31:0]  buf_pc_reg    [2];
    logic [31:0]  buf_instr_reg [2];

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_F    = (occ_reg != 2'd0);
        push       = imem.imem_rvalid && (state_reg != ST_DROP) && !redirect;
        pop        = valid_F && !stall_F && !redirect;
        occ_next   = occ_reg + 2'(push) - 2'(pop);
        tail       = head_reg ^ occ_reg[0];
        // A slot is reserved at issue time, so every accepted response has room.
        req        = !rst && !redirect
                     && ((state_reg == ST_IDLE) || imem.imem_rvalid)
                     && (occ_next < 2'd2);
        handshake  = req && imem.imem_ready;

        if (redirect) begin
            pc_next    = {redirect_pc[31:2], 2'b00};
            state_next = ((state_reg != ST_IDLE) && !imem.imem_rvalid) ? ST_DROP : ST_IDLE;
        end else if (handshake) begin
            pc_next    = pc_reg + 32'd4;
            state_next = ST_WAIT;
        end else if (imem.imem_rvalid) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            req_pc_reg <= RESET_PC;
            occ_reg    <= 2'd0;
            head_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            occ_reg   <= redirect ? 2'd0 : occ_next;
            head_reg  <= head_reg ^ pop;
            if (handshake) begin
                req_pc_reg <= pc_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && (tail == 1'(gi))) begin
                    buf_pc_reg[gi]    <= req_pc_reg;
                    buf_instr_reg[gi] <= imem.imem_rdata;
                end
            end
        end
    endgenerate

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;
    assign instr_F        = valid_F ? buf_instr_reg[head_reg] : NOP_INSTR;
    assign pc_F           = valid_F ? buf_pc_reg[head_reg]    : 32'h0000_0000;

endmodule
